msg_match_engine: RTL and testbench

Parametrised MPI receive-side matching engine with an unexpected-message queue (UMQ), source/tag wildcards, and eager plus rendezvous (RTS/CTS/DATA) receives. It sits between the router packet port and the NIOS custom-instruction interface. Posted receives are matched against queued arrivals in MPI arrival order, and payload words are written to main memory.

---
 rtl/msg_match_engine.sv | 265 ++++++++++++++++++++++++++
 tb/tb_msg_match_engine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_match_engine.sv
// MPI receive-side matching engine: unexpected-message queue, wildcards,
// eager and rendezvous (RTS/CTS/DATA) receives.
module msg_match_engine #(
    parameter int PKT_W     = 128,
    parameter int DATA_W    = 32,
    parameter int SRC_W     = 8,
    parameter int TAG_W     = 8,
    parameter int ADDR_W    = 11,
    parameter int UMQ_DEPTH = 8
) (
    input  logic              nios_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       data_in_a,
    input  logic [31:0]       data_in_b,
    input  logic [2:0]        in_opcode,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              overflow,
    output logic              stray,
    input  logic [PKT_W-1:0]  packet_in,
    output logic [PKT_W-1:0]  packet_out,
    output logic              packet_out_valid,
    output logic              write,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] data_to_mem
);
    localparam int IDX_W = $clog2(UMQ_DEPTH);
    localparam int CNT_W = $clog2(UMQ_DEPTH + 1);
    localparam int PAD_W = PKT_W - 8 - SRC_W - TAG_W - ADDR_W;
    localparam logic [4:0] T_EAGER = 5'b10000;
    localparam logic [4:0] T_RTS   = 5'b10001;
    localparam logic [4:0] T_DATA  = 5'b11000;
    localparam logic [4:0] T_CTS   = 5'b01110;

    typedef enum logic [2:0] {
        IDLE, MATCH, WAIT_MSG, DONE_E, SEND_CTS, RECV_DATA
    } state_t;

    typedef struct packed {
        logic              is_rts;
        logic [SRC_W-1:0]  src;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] size;
        logic [DATA_W-1:0] payload;
    } entry_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  req_src_q, req_src_d;
    logic [TAG_W-1:0]  req_tag_q, req_tag_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        opc_q, opc_d;
    logic [ADDR_W-1:0] msg_size_q, msg_size_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    entry_t            umq_q [UMQ_DEPTH];
    entry_t            umq_d [UMQ_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              stray_q, stray_d;
    logic [PKT_W-1:0]  pkt_out_q, pkt_out_d;
    logic              pov_q, pov_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [4:0]        p_type;
    logic              p_msg, p_data, p_hit;
    entry_t            arr, tk;
    logic              hit, rm, app, take;
    logic [IDX_W-1:0]  hit_idx;
    logic              unused_bits;

    assign p_type = packet_in[127:123];
    assign p_msg  = (p_type == T_EAGER) || (p_type == T_RTS);
    assign p_data = (p_type == T_DATA);
    assign unused_bits = ^{data_in_a[31:16], data_in_b[31:22],
                           packet_in[122:120], packet_in[92:88],
                           packet_in[55:11]};

    function automatic logic req_match(input logic [SRC_W-1:0] s,
                                       input logic [TAG_W-1:0] t);
        return ((req_src_q == '1) || (req_src_q == s)) &&
               ((req_tag_q == '1) || (req_tag_q == t));
    endfunction

    always_comb begin
        arr.is_rts  = (p_type == T_RTS);
        arr.src     = packet_in[119:112];
        arr.tag     = packet_in[111:104];
        arr.size    = packet_in[103:93];
        arr.payload = packet_in[87:56];
        p_hit       = p_msg && req_match(arr.src, arr.tag);
    end

    // Scan downward so the lowest (oldest) hitting slot wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = UMQ_DEPTH - 1; i >= 0; i--) begin
            if ((CNT_W'(i) < cnt_q) &&
                req_match(umq_q[i].src, umq_q[i].tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_src_d  = req_src_q;
        req_tag_d  = req_tag_q;
        base_d     = base_q;
        opc_d      = opc_q;
        msg_size_d = msg_size_q;
        wcnt_d     = wcnt_q;
        result_d   = result_q;
        done_d     = 1'b0;
        pkt_out_d  = '0;
        pov_d      = 1'b0;
        write_d    = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rm         = 1'b0;
        take       = 1'b0;
        tk         = arr;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    req_src_d = data_in_a[8 +: SRC_W];
                    req_tag_d = data_in_a[0 +: TAG_W];
                    base_d    = data_in_b[21:11];
                    opc_d     = in_opcode;
                    state_d   = MATCH;
                end
            end
            MATCH: begin
                if (hit) begin
                    rm   = 1'b1;
                    take = 1'b1;
                    tk   = umq_q[hit_idx];
                end else begin
                    state_d = WAIT_MSG;
                end
            end
            WAIT_MSG: take = p_hit;
            DONE_E:   state_d = IDLE;
            SEND_CTS: state_d = (msg_size_q == '0) ? IDLE : RECV_DATA;
            RECV_DATA: begin
                if (p_data) begin
                    write_d = 1'b1;
                    waddr_d = base_q + packet_in[ADDR_W-1:0];
                    wdata_d = packet_in[87:56];
                    wcnt_d  = wcnt_q + ADDR_W'(1);
                    if (packet_in[ADDR_W-1:0] == msg_size_q - ADDR_W'(1)) begin
                        done_d   = 1'b1;
                        result_d = DATA_W'(wcnt_q) + DATA_W'(1);
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            if (!tk.is_rts) begin
                state_d  = DONE_E;
                write_d  = 1'b1;
                waddr_d  = base_q;
                wdata_d  = tk.payload;
                result_d = tk.payload;
                done_d   = 1'b1;
            end else begin
                state_d    = SEND_CTS;
                pov_d      = 1'b1;
                pkt_out_d  = {T_CTS, opc_q, tk.src, tk.tag, tk.size,
                              {PAD_W{1'b0}}};
                msg_size_d = tk.size;
                wcnt_d     = '0;
                if (tk.size == '0) begin
                    done_d   = 1'b1;
                    result_d = '0;
                end
            end
        end
        app     = p_msg && !((state_q == WAIT_MSG) && p_hit);
        stray_d = stray_q | (p_data && (state_q != RECV_DATA));
    end

    // Removal compacts first; the append then lands at the new count.
    always_comb begin
        umq_d = umq_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rm) begin
            for (int i = 0; i < UMQ_DEPTH - 1; i++) begin
                if (IDX_W'(i) >= hit_idx) umq_d[i] = umq_q[i + 1];
            end
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (app) begin
            if (cnt_d == CNT_W'(UMQ_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < UMQ_DEPTH; i++) begin
                    if (CNT_W'(i) == cnt_d) umq_d[i] = arr;
                end
                cnt_d = cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge nios_clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_src_q  <= '0;
            req_tag_q  <= '0;
            base_q     <= '0;
            opc_q      <= '0;
            msg_size_q <= '0;
            wcnt_q     <= '0;
            for (int i = 0; i < UMQ_DEPTH; i++) umq_q[i] <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            stray_q    <= 1'b0;
            pkt_out_q  <= '0;
            pov_q      <= 1'b0;
            write_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_src_q  <= req_src_d;
            req_tag_q  <= req_tag_d;
            base_q     <= base_d;
            opc_q      <= opc_d;
            msg_size_q <= msg_size_d;
            wcnt_q     <= wcnt_d;
            for (int i = 0; i < UMQ_DEPTH; i++) umq_q[i] <= umq_d[i];
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            stray_q    <= stray_d;
            pkt_out_q  <= pkt_out_d;
            pov_q      <= pov_d;
            write_q    <= write_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign result           = result_q;
    assign done             = done_q;
    assign overflow         = ovf_q;
    assign stray            = stray_q;
    assign packet_out       = pkt_out_q;
    assign packet_out_valid = pov_q;
    assign write            = write_q;
    assign write_addr       = waddr_q;
    assign data_to_mem      = wdata_q;

endmodule

// File: tb/tb_msg_match_engine.sv
// Directed bench for msg_match_engine: eager, rendezvous, ordering,
// overflow, address wrap, stray DATA, zero-size RTS and mid-run reset.
module tb_msg_match_engine;
    logic         nios_clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  data_in_a, data_in_b;
    logic [2:0]   in_opcode;
    logic [31:0]  result;
    logic         done, overflow, stray;
    logic [127:0] packet_in, packet_out;
    logic         packet_out_valid, write;
    logic [10:0]  write_addr;
    logic [31:0]  data_to_mem;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [4:0] EAGER = 5'b10000;
    localparam logic [4:0] RTS   = 5'b10001;
    localparam logic [4:0] DATA  = 5'b11000;
    localparam logic [2:0] OPC   = 3'b101;

    msg_match_engine dut (
        .nios_clk(nios_clk), .reset(reset), .start(start),
        .data_in_a(data_in_a), .data_in_b(data_in_b),
        .in_opcode(in_opcode), .result(result), .done(done),
        .overflow(overflow), .stray(stray), .packet_in(packet_in),
        .packet_out(packet_out), .packet_out_valid(packet_out_valid),
        .write(write), .write_addr(write_addr),
        .data_to_mem(data_to_mem)
    );

    always #5 nios_clk = ~nios_clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge nios_clk);
        #1;
    endtask

    function automatic logic [127:0] pkt(input logic [4:0] t,
        input logic [7:0] s, input logic [7:0] g, input logic [10:0] sz,
        input logic [31:0] pay, input logic [10:0] idx);
        logic [127:0] p;
        p = '0;
        p[127:123] = t;
        p[119:112] = s;
        p[111:104] = g;
        p[103:93]  = sz;
        p[87:56]   = pay;
        p[10:0]    = idx;
        return p;
    endfunction

    function automatic logic [127:0] cts(input logic [7:0] s,
        input logic [7:0] g, input logic [10:0] sz);
        return {5'b01110, OPC, s, g, sz, 93'b0};
    endfunction

    task automatic send(input logic [127:0] p);
        packet_in = p;
        tick();
        packet_in = '0;
    endtask

    task automatic post(input logic [7:0] s, input logic [7:0] g,
                        input logic [10:0] sz, input logic [10:0] base);
        start     = 1'b1;
        data_in_a = {16'h0, s, g};
        data_in_b = {10'h0, base, sz};
        tick();
        start     = 1'b0;
    endtask

    task automatic expect_eager(input string tag, input logic [10:0] a,
                                input logic [31:0] d);
        check({tag, ".write"}, write, 1);
        check({tag, ".addr"}, write_addr, a);
        check({tag, ".data"}, data_to_mem, d);
        check({tag, ".done"}, done, 1);
        check({tag, ".result"}, result, d);
    endtask

    task automatic rx_data(input string tag, input logic [10:0] base,
                           input int n, input int total);
        logic [10:0] a;
        for (int i = 0; i < n; i++) begin
            packet_in = pkt(DATA, 0, 0, 0, 32'hA000_0000 + i, 11'(i));
            tick();
            packet_in = '0;
            a = base + 11'(i);
            check({tag, ".wr"}, write, 1);
            check({tag, ".addr"}, write_addr, a);
            check({tag, ".data"}, data_to_mem, 32'hA000_0000 + i);
            check({tag, ".done"}, done, (i == total - 1));
            if (i == total - 1) check({tag, ".result"}, result, total);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; data_in_a = '0; data_in_b = '0;
        in_opcode = OPC; packet_in = '0;
        tick(); tick();
        check("rst.done", done, 0);
        check("rst.write", write, 0);
        check("rst.result", result, 0);
        check("rst.pov", packet_out_valid, 0);
        check("rst.flags", {overflow, stray}, 0);
        check("rst.cnt", dut.cnt_q, 0);
        reset = 1'b1;
        tick();

        // Unexpected eager
        send(pkt(EAGER, 2, 5, 1, 32'hDEADBEEF, 0));
        check("ue.cnt1", dut.cnt_q, 1);
        post(2, 5, 1, 11'h040);
        check("ue.c1_nowrite", write, 0);
        tick();
        expect_eager("ue", 11'h040, 32'hDEADBEEF);
        check("ue.cnt0", dut.cnt_q, 0);
        tick();
        check("ue.pulse", {done, write}, 0);

        // Posted rendezvous
        post(1, 3, 4, 11'h100);
        tick();
        send(pkt(RTS, 1, 3, 4, 0, 0));
        check("rv.pov", packet_out_valid, 1);
        check("rv.cts", packet_out, cts(1, 3, 4));
        check("rv.cnt", dut.cnt_q, 0);
        tick();
        check("rv.pov_pulse", packet_out_valid, 0);
        rx_data("rv", 11'h100, 4, 4);
        tick();
        check("rv.end", {done, write}, 0);
        check("rv.stray", stray, 0);

        // Ordering and wildcard
        send(pkt(EAGER, 0, 7, 1, 32'hAAAA, 0));
        send(pkt(EAGER, 1, 7, 1, 32'hBBBB, 0));
        send(pkt(EAGER, 0, 7, 1, 32'hCCCC, 0));
        post(8'hFF, 7, 1, 11'h010);
        tick();
        expect_eager("ord.A", 11'h010, 32'hAAAA);
        tick();
        check("ord.cnt2", dut.cnt_q, 2);
        post(0, 7, 1, 11'h011);
        tick();
        expect_eager("ord.C", 11'h011, 32'hCCCC);
        tick();
        post(8'hFF, 8'hFF, 1, 11'h012);
        tick();
        expect_eager("ord.B", 11'h012, 32'hBBBB);
        tick();
        check("ord.cnt0", dut.cnt_q, 0);

        // Overflow
        for (int i = 0; i < 9; i++) begin
            send(pkt(EAGER, 9, 8'(i), 1, 32'h100 + i, 0));
            if (i == 7) check("ovf.before", overflow, 0);
        end
        check("ovf.flag", overflow, 1);
        check("ovf.cnt8", dut.cnt_q, 8);
        post(9, 0, 1, 11'h020);
        send(pkt(EAGER, 9, 20, 1, 32'h555, 0));
        expect_eager("ovf.rm", 11'h020, 32'h100);
        check("ovf.cnt_swap", dut.cnt_q, 8);
        tick();
        post(9, 20, 1, 11'h021);
        tick();
        expect_eager("ovf.app", 11'h021, 32'h555);
        check("ovf.cnt7", dut.cnt_q, 7);
        tick();
        reset = 1'b0;
        #1;
        check("ovf.rst_flag", overflow, 0);
        check("ovf.rst_cnt", dut.cnt_q, 0);
        tick();
        reset = 1'b1;
        tick();

        // Address wrap with an unexpected RTS
        send(pkt(RTS, 6, 6, 4, 0, 0));
        post(6, 6, 4, 11'h7FE);
        tick();
        check("wr.pov", packet_out_valid, 1);
        check("wr.cts", packet_out, cts(6, 6, 4));
        tick();
        rx_data("wr", 11'h7FE, 4, 4);
        tick();

        // Stray DATA in IDLE
        check("st.before", stray, 0);
        send(pkt(DATA, 0, 0, 0, 32'h1234, 0));
        check("st.flag", stray, 1);
        check("st.nowrite", write, 0);

        // Zero-size RTS
        post(4, 4, 0, 11'h030);
        tick();
        send(pkt(RTS, 4, 4, 0, 0, 0));
        check("z.pov", packet_out_valid, 1);
        check("z.cts", packet_out, cts(4, 4, 0));
        check("z.done", done, 1);
        check("z.result", result, 0);
        check("z.nowrite", write, 0);
        tick();
        check("z.after", {done, write, packet_out_valid}, 0);

        // Reset during RECV_DATA after 2 of 4 words
        send(pkt(EAGER, 7, 7, 1, 32'h7777, 0));
        post(3, 3, 4, 11'h200);
        tick();
        send(pkt(RTS, 3, 3, 4, 0, 0));
        check("mr.cts", packet_out, cts(3, 3, 4));
        tick();
        rx_data("mr", 11'h200, 2, 4);
        reset = 1'b0;
        #1;
        check("mr.outs", {result, done, write, write_addr, data_to_mem,
                          packet_out_valid, overflow, stray}, 0);
        check("mr.pkt", packet_out, 0);
        check("mr.cnt", dut.cnt_q, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr.nodone", done, 0);
        end
        reset = 1'b1;
        tick();
        send(pkt(EAGER, 2, 2, 1, 32'hCAFE, 0));
        post(2, 2, 1, 11'h033);
        tick();
        expect_eager("mr.new", 11'h033, 32'hCAFE);
        tick();
        check("mr.pulse", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
